counter_multimode: RTL and testbench

- Parametrised general-purpose event/timing counter for the DSP datapath: sample-slot, frame and subcode timing.
- Generalises the inhibitable saturating/auto-reset counter:
  - up/down counting
  - four wrap modes
  - synchronous parallel load
  - built-in clock-enable prescaler
  - registered terminal-count pulse
- Single clock domain; feeds sequencers and frame-timing logic.

---
 rtl/counter_multimode.sv | 139 +++++++++++++
 tb/tb_counter_multimode.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_multimode.sv
// Up/down event counter: four wrap modes, clamped parallel load, enable prescaler, registered tc/done.
// Defining COUNTER_MULTIMODE_SNAPSHOT_EN adds the snapStb/snapVal capture register.
module counter_multimode #(
    parameter int DATA_WIDTH     = 8,
    parameter int VAL_RST        = 0,
    parameter int VAL_MIN        = 0,
    parameter int VAL_MAX        = 2**DATA_WIDTH - 1,
    parameter int PRESCALE_DIV   = 1,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clkInhibit,
    input  logic                  dirDown,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] loadVal,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  tc,
    output logic                  done
`ifdef COUNTER_MULTIMODE_SNAPSHOT_EN
    ,
    input  logic                  snapStb,
    output logic [DATA_WIDTH-1:0] snapVal
`endif
);

    typedef enum logic [1:0] {
        MODE_SATURATE = 2'd0,
        MODE_WRAP     = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_RELOAD   = 2'd3
    } mode_e;

    localparam logic [DATA_WIDTH-1:0]     RST_V      = DATA_WIDTH'(VAL_RST);
    localparam logic [DATA_WIDTH-1:0]     MIN_V      = DATA_WIDTH'(VAL_MIN);
    localparam logic [DATA_WIDTH-1:0]     MAX_V      = DATA_WIDTH'(VAL_MAX);
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_LAST = PRESCALE_WIDTH'(PRESCALE_DIV - 1);

    mode_e                     mode_w;
    logic [DATA_WIDTH-1:0]     cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      tc_q, tc_d;
    logic                      done_q, done_d;
    logic                      step;
    logic [DATA_WIDTH-1:0]     bound, opposite, moved, load_clamped;

    assign mode_w   = mode_e'(mode);
    assign bound    = dirDown ? MIN_V : MAX_V;
    assign opposite = dirDown ? MAX_V : MIN_V;
    assign moved    = dirDown ? cnt_q - 1'b1 : cnt_q + 1'b1;

    // Compare in int so bounds at the edges of the unsigned range stay meaningful.
    always_comb begin
        load_clamped = loadVal;
        if (int'(loadVal) < VAL_MIN)
            load_clamped = MIN_V;
        else if (int'(loadVal) > VAL_MAX)
            load_clamped = MAX_V;
    end

    // The prescaler keeps running while a finished ONESHOT ignores its steps.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        presc_d = presc_q;
        step    = 1'b0;
        if (load) begin
            presc_d = '0;
        end else if (!clkInhibit) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                step    = !(mode_w == MODE_ONESHOT && done_q);
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        done_d = done_q;
        if (load) begin
            cnt_d  = load_clamped;
            done_d = 1'b0;
        end else if (step) begin
            if (cnt_q != bound) begin
                cnt_d = moved;
                tc_d  = (moved == bound);
            end else begin
                unique case (mode_w)
                    MODE_SATURATE: cnt_d = cnt_q;
                    MODE_WRAP: begin
                        cnt_d = opposite;
                        tc_d  = 1'b1;
                    end
                    MODE_ONESHOT:  done_d = 1'b1;
                    MODE_RELOAD: begin
                        cnt_d = RST_V;
                        tc_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= RST_V;
            presc_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign out  = cnt_q;
    assign tc   = tc_q;
    assign done = done_q;

`ifdef COUNTER_MULTIMODE_SNAPSHOT_EN
    logic [DATA_WIDTH-1:0] snap_q;

    always_ff @(posedge clk) begin
        if (rst)
            snap_q <= RST_V;
        else if (snapStb)
            snap_q <= cnt_q;
    end

    assign snapVal = snap_q;
`endif

endmodule

// File: tb/tb_counter_multimode.sv
// Scoreboard bench for counter_multimode: two parameterisations share random/directed stimulus
// and are checked against an integer reference model of the counting rules.
module tb_counter_multimode;

    localparam int DW = 4;
    // Instance A: plain 0..9 counter, every enabled clock steps.
    localparam int A_MIN = 0, A_MAX = 9,  A_RST = 0, A_DIV = 1;
    // Instance B: offset bounds, non-zero reset value, divide-by-4 prescaler.
    localparam int B_MIN = 2, B_MAX = 12, B_RST = 7, B_DIV = 4;

    typedef struct {
        int out;
        int presc;
        bit tc;
        bit done;
        int snap;
    } mstate_t;

    typedef struct {
        bit rst;
        bit inh;
        bit dir;
        int md;
        bit ld;
        int lv;
        bit snap;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst, clkInhibit, dirDown, load;
    logic [1:0]    mode;
    logic [DW-1:0] loadVal;
    logic [DW-1:0] out_a, out_b;
    logic          tc_a, tc_b, done_a, done_b;
`ifdef COUNTER_MULTIMODE_SNAPSHOT_EN
    logic          snap_stb;
    logic [DW-1:0] snap_val_a, snap_val_b;
`endif

    mstate_t sa, sb, exp_a, exp_b;
    mstate_t q_a[$];
    mstate_t q_b[$];
    int      n_vec  = 0;
    int      n_fail = 0;

    always #5 clk = ~clk;

    counter_multimode #(
        .DATA_WIDTH(DW), .VAL_RST(A_RST), .VAL_MIN(A_MIN), .VAL_MAX(A_MAX),
        .PRESCALE_DIV(A_DIV), .PRESCALE_WIDTH(8)
    ) dut_a (
        .clk(clk), .rst(rst), .clkInhibit(clkInhibit), .dirDown(dirDown), .mode(mode),
        .load(load), .loadVal(loadVal), .out(out_a), .tc(tc_a), .done(done_a)
`ifdef COUNTER_MULTIMODE_SNAPSHOT_EN
        , .snapStb(snap_stb), .snapVal(snap_val_a)
`endif
    );

    counter_multimode #(
        .DATA_WIDTH(DW), .VAL_RST(B_RST), .VAL_MIN(B_MIN), .VAL_MAX(B_MAX),
        .PRESCALE_DIV(B_DIV), .PRESCALE_WIDTH(3)
    ) dut_b (
        .clk(clk), .rst(rst), .clkInhibit(clkInhibit), .dirDown(dirDown), .mode(mode),
        .load(load), .loadVal(loadVal), .out(out_b), .tc(tc_b), .done(done_b)
`ifdef COUNTER_MULTIMODE_SNAPSHOT_EN
        , .snapStb(snap_stb), .snapVal(snap_val_b)
`endif
    );

    // Reference: what one clock edge does to the counter, written from the counting rules.
    function automatic mstate_t model_next(mstate_t s, int vmin, int vmax, int vrst, int div,
                                           stim_t st);
        mstate_t n;
        int      b, o;
        n    = s;
        n.tc = 1'b0;
        if (st.rst) begin
            n.out = vrst; n.presc = 0; n.done = 1'b0; n.snap = vrst;
            return n;
        end
        if (st.snap) n.snap = s.out;
        if (st.ld) begin
            n.out   = (st.lv < vmin) ? vmin : (st.lv > vmax) ? vmax : st.lv;
            n.presc = 0;
            n.done  = 1'b0;
            return n;
        end
        if (st.inh) return n;
        if (s.presc != div - 1) begin
            n.presc = s.presc + 1;
            return n;
        end
        n.presc = 0;
        if (st.md == 2 && s.done) return n;
        b = st.dir ? vmin : vmax;
        o = st.dir ? vmax : vmin;
        if (s.out != b) begin
            n.out = st.dir ? s.out - 1 : s.out + 1;
            n.tc  = (n.out == b);
        end else begin
            case (st.md)
                1: begin n.out = o;    n.tc = 1'b1; end
                2: n.done = 1'b1;
                3: begin n.out = vrst; n.tc = 1'b1; end
                default: ;
            endcase
        end
        return n;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic drive(input bit r, input bit inh, input bit dir, input int md,
                         input bit ld, input int lv, input bit sn);
        stim_t st;
        st = '{rst: r, inh: inh, dir: dir, md: md, ld: ld, lv: lv, snap: sn};
        @(negedge clk);
        rst        = r;
        clkInhibit = inh;
        dirDown    = dir;
        mode       = 2'(md);
        load       = ld;
        loadVal    = DW'(lv);
`ifdef COUNTER_MULTIMODE_SNAPSHOT_EN
        snap_stb   = sn;
`endif
        sa = model_next(sa, A_MIN, A_MAX, A_RST, A_DIV, st);
        sb = model_next(sb, B_MIN, B_MAX, B_RST, B_DIV, st);
        q_a.push_back(sa);
        q_b.push_back(sb);
    endtask

    task automatic run(input int n, input bit dir, input int md);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, dir, md, 1'b0, 0, 1'b0);
    endtask

    task automatic do_load(input bit dir, input int md, input int lv);
        drive(1'b0, 1'b0, dir, md, 1'b1, lv, 1'b0);
    endtask

    // Monitors: one pop-and-compare per edge, sampled 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        if (q_a.size() != 0) begin
            exp_a = q_a.pop_front();
            check("a.out",  int'(out_a),  exp_a.out);
            check("a.tc",   int'(tc_a),   int'(exp_a.tc));
            check("a.done", int'(done_a), int'(exp_a.done));
`ifdef COUNTER_MULTIMODE_SNAPSHOT_EN
            check("a.snap", int'(snap_val_a), exp_a.snap);
`endif
        end
    end

    always @(posedge clk) begin
        #1;
        if (q_b.size() != 0) begin
            exp_b = q_b.pop_front();
            check("b.out",  int'(out_b),  exp_b.out);
            check("b.tc",   int'(tc_b),   int'(exp_b.tc));
            check("b.done", int'(done_b), int'(exp_b.done));
`ifdef COUNTER_MULTIMODE_SNAPSHOT_EN
            check("b.snap", int'(snap_val_b), exp_b.snap);
`endif
        end
    end

    initial begin
        rst = 1'b1; clkInhibit = 1'b0; dirDown = 1'b0; mode = 2'd1; load = 1'b0; loadVal = '0;
`ifdef COUNTER_MULTIMODE_SNAPSHOT_EN
        snap_stb = 1'b0;
`endif
        sa = '{out: A_RST, presc: 0, tc: 1'b0, done: 1'b0, snap: A_RST};
        sb = '{out: B_RST, presc: 0, tc: 1'b0, done: 1'b0, snap: B_RST};

        drive(1'b1, 1'b0, 1'b0, 1, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1, 1'b0, 0, 1'b0);

        // WRAP up from reset; snapshot taken on the 4 -> 5 edge of instance A.
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0, 1, 1'b0, 0, i == 4);
        run(4, 1'b0, 1);

        // SATURATE down after load of 2.
        do_load(1'b1, 0, 2);
        run(5, 1'b1, 0);

        // ONESHOT up from 7, long hold after completion, then reload with 3.
        do_load(1'b0, 2, 7);
        run(13, 1'b0, 2);
        do_load(1'b0, 2, 3);
        run(3, 1'b0, 2);

        // Prescaled WRAP with a three-cycle inhibit gap.
        do_load(1'b0, 1, 0);
        run(6, 1'b0, 1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0);
        run(10, 1'b0, 1);

        // Reset beats load; loads above and below the bounds clamp.
        drive(1'b1, 1'b0, 1'b0, 1, 1'b1, 5, 1'b0);
        do_load(1'b0, 1, 15);
        run(3, 1'b0, 1);
        do_load(1'b1, 1, 0);
        run(3, 1'b1, 1);

        // RELOAD, both directions, including a load honoured under inhibit.
        do_load(1'b0, 3, 5);
        run(14, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b1, 3, 1'b1, 8, 1'b0);
        run(14, 1'b1, 3);

        // Randomised traffic: direction/mode changes mid-count, sparse loads and resets.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        for (int i = 0; i < 4 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d responses outstanding, expected 0/0", q_a.size(), q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
